// File: rtl/fact_master.sv
// Bus initiator for the factorial accelerator: takes n on a valid/ready port,
// writes n and go, polls status with a bounded budget, reads the result and returns it.
module fact_master #(
  parameter int N_W        = 4,
  parameter int DATA_W     = 32,
  parameter int POLL_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [N_W-1:0]    req_n,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_err,
  output logic              resp_timeout,
  output logic [1:0]        bus_a,
  output logic              bus_we,
  output logic [N_W-1:0]    bus_wd,
  input  logic [DATA_W-1:0] bus_rd
);

  localparam int CNT_W = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(POLL_LIMIT - 1);

  localparam logic [1:0] A_IN  = 2'b00;
  localparam logic [1:0] A_GO  = 2'b01;
  localparam logic [1:0] A_ST  = 2'b10;
  localparam logic [1:0] A_RES = 2'b11;

  typedef enum logic [2:0] {
    IDLE, WR_N, WR_GO, SETTLE, POLL, RD_RES, RESP
  } state_e;

  state_e              state_q, state_d;
  logic [N_W-1:0]      n_q, n_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                err_q, err_d;
  logic                to_q, to_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    to_d    = to_q;
    case (state_q)
      IDLE:   if (req_valid) begin
                n_d     = req_n;
                state_d = WR_N;
              end
      WR_N:   state_d = WR_GO;
      WR_GO:  state_d = SETTLE;
      // status may still show done from the previous run here, so it is not sampled
      SETTLE: begin
                cnt_d   = '0;
                state_d = POLL;
              end
      POLL:   if (bus_rd[1]) begin
                res_d   = '0;
                err_d   = 1'b1;
                to_d    = 1'b0;
                state_d = RESP;
              end else if (bus_rd[0]) begin
                state_d = RD_RES;
              end else if (cnt_q == CNT_MAX) begin
                res_d   = '0;
                err_d   = 1'b1;
                to_d    = 1'b1;
                state_d = RESP;
              end else begin
                cnt_d   = cnt_q + 1'b1;
              end
      RD_RES: begin
                res_d   = bus_rd;
                err_d   = 1'b0;
                to_d    = 1'b0;
                state_d = RESP;
              end
      RESP:   if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // bus and handshake outputs decode state only, keeping bus_rd off any output path
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    bus_a      = A_ST;
    bus_we     = 1'b0;
    bus_wd     = '0;
    case (state_q)
      IDLE:   req_ready = 1'b1;
      WR_N:   begin
                bus_a  = A_IN;
                bus_we = 1'b1;
                bus_wd = n_q;
              end
      WR_GO:  begin
                bus_a  = A_GO;
                bus_we = 1'b1;
                bus_wd = N_W'(1);
              end
      RD_RES: bus_a = A_RES;
      RESP:   resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign resp_result  = res_q;
  assign resp_err     = err_q;
  assign resp_timeout = to_q;

endmodule

// File: tb/tb_fact_master.sv
// Scoreboard bench for fact_master against a behavioural accelerator slave
// with configurable done delay, error, never-done and stale-done behaviour.
module tb_fact_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [3:0]  req_n;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_result;
  logic        resp_err, resp_timeout;
  logic [1:0]  bus_a;
  logic        bus_we;
  logic [3:0]  bus_wd;
  logic [31:0] bus_rd;

  fact_master #(.N_W(4), .DATA_W(32), .POLL_LIMIT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_err(resp_err), .resp_timeout(resp_timeout),
    .bus_a(bus_a), .bus_we(bus_we), .bus_wd(bus_wd), .bus_rd(bus_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        err;
    logic        to;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0;
  int          nerr = 0;
  logic [6:0]  trace [0:7];
  int          rd11;

  // slave configuration
  int   dly   = 1;
  logic never = 1'b0;
  logic errm  = 1'b0;
  logic stale = 1'b0;

  logic [3:0] sl_n    = '0;
  logic       started = 1'b0;
  int         since   = 0;

  function automatic logic [31:0] fact(input logic [3:0] n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * i;
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus_we && bus_a == 2'b00) sl_n <= bus_wd;
    if (bus_we && bus_a == 2'b01 && bus_wd == 4'd1) begin
      started <= 1'b1;
      since   <= 0;
    end else if (started && since < 1000) begin
      since <= since + 1;
    end
  end

  always_comb begin
    logic done, errb;
    done   = started && ((since >= dly && !never) || (stale && since == 0));
    errb   = started && errm && since >= 1;
    bus_rd = '0;
    if (bus_a == 2'b11)      bus_rd = fact(sl_n);
    else if (bus_a == 2'b10) bus_rd = {30'b0, errb, done};
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_req(input logic [3:0] n, input logic [31:0] res, input logic err,
                        input logic to, input int lat_exp, input int hold);
    exp_t e;
    int   lat, w;
    sb.push_back('{res, err, to, lat_exp});
    @(negedge clk);
    req_n = n; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    chk("req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_n = 4'hF;
    lat = 0; rd11 = 0;
    while (!resp_valid && lat < 200) begin
      if (lat < 8) trace[lat] = {bus_a, bus_we, bus_wd};
      if (bus_a == 2'b11) rd11++;
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk("resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("latency", lat, e.lat);
    chk("result", resp_result, e.res);
    chk("err", {31'b0, resp_err}, {31'b0, e.err});
    chk("timeout", {31'b0, resp_timeout}, {31'b0, e.to});
    for (int i = 0; i < hold; i++) begin
      req_valid = i[0]; req_n = 4'h7;
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_result", resp_result, e.res);
      chk("hold_flags", {30'b0, resp_err, resp_timeout}, {30'b0, e.err, e.to});
      chk("hold_rdy", {31'b0, req_ready}, 32'd0);
    end
    // request held high across the handshake edge must not be taken
    req_valid = 1'b1; req_n = 4'h7; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    chk("resp_drop", {31'b0, resp_valid}, 32'd0);
    chk("idle_rdy", {31'b0, req_ready}, 32'd1);
    chk("res_kept", resp_result, e.res);
  endtask

  task automatic reset_at(input int cyc_after);
    @(negedge clk);
    req_n = 4'd9; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (cyc_after) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_we", {31'b0, bus_we}, 32'd0);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdy", {31'b0, req_ready}, 32'd1);
    chk("rst_a", {30'b0, bus_a}, 32'd2);
    @(negedge clk) rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_noresp", {31'b0, resp_valid}, 32'd0);
    end
  endtask

  logic [31:0] ftab [1:12];

  initial begin
    ftab = '{32'd1, 32'd2, 32'd6, 32'd24, 32'd120, 32'd720, 32'd5040, 32'd40320,
             32'd362880, 32'd3628800, 32'd39916800, 32'd479001600};
    rst = 1'b0; req_valid = 1'b0; req_n = '0; resp_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_err_to", {30'b0, resp_err, resp_timeout}, 32'd0);
    chk("rst_bus_a", {30'b0, bus_a}, 32'd2);
    chk("rst_bus_we", {31'b0, bus_we}, 32'd0);
    chk("rst_bus_wd", {28'b0, bus_wd}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // 1: basic n=3 with bus trace
    do_req(4'd3, 32'd6, 1'b0, 1'b0, 5, 0);
    chk("tr_wr_n",  {25'b0, trace[0]}, {25'b0, 2'b00, 1'b1, 4'd3});
    chk("tr_wr_go", {25'b0, trace[1]}, {25'b0, 2'b01, 1'b1, 4'd1});
    chk("tr_settle", {25'b0, trace[2]}, {25'b0, 2'b10, 1'b0, 4'd0});
    chk("tr_poll",  {25'b0, trace[3]}, {25'b0, 2'b10, 1'b0, 4'd0});
    chk("tr_rd",    {25'b0, trace[4]}, {25'b0, 2'b11, 1'b0, 4'd0});

    // 2: error with done also set, err wins and result is never read
    errm = 1'b1;
    do_req(4'd13, 32'd0, 1'b1, 1'b0, 4, 0);
    chk("err_no_rd11", rd11, 32'd0);
    errm = 1'b0;

    // 3: never done -> timeout after 3+64 cycles
    never = 1'b1;
    do_req(4'd4, 32'd0, 1'b1, 1'b1, 67, 0);
    never = 1'b0;

    // 4: stale done during SETTLE, real done later
    do_req(4'd2, 32'd2, 1'b0, 1'b0, 5, 0);
    stale = 1'b1; dly = 5;
    do_req(4'd6, 32'd720, 1'b0, 1'b0, 9, 0);
    stale = 1'b0; dly = 1;

    // 5: consumer stalls for 10 cycles
    do_req(4'd7, 32'd5040, 1'b0, 1'b0, 5, 10);
    do_req(4'd0, 32'd1, 1'b0, 1'b0, 5, 0);

    // 6: back-to-back sweep, with one slower slave run
    for (int k = 1; k <= 12; k++) do_req(4'(k), ftab[k], 1'b0, 1'b0, 5, 0);
    dly = 3;
    do_req(4'd8, 32'd40320, 1'b0, 1'b0, 7, 0);
    dly = 1;

    never = 1'b1;
    reset_at(6);
    reset_at(0);
    never = 1'b0;
    do_req(4'd5, 32'd120, 1'b0, 1'b0, 5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fact_master.md
Name: fact_master

Overview:
- Hardware initiator for the 2-bit-address factorial accelerator register interface.
- Accepts a factorial request (n) on a valid/ready port and runs the bus sequence: write n, write go, poll status, read result.
- Returns result/error on a valid/ready response port.
- Sits between the MIPS32 core's I/O path and the factorial accelerator, replacing software polling.

Parameters:
N_W, 4, width of request operand and bus write data
DATA_W, 32, width of bus read data and result
POLL_LIMIT, 64, max status-poll cycles before timeout (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept request (IDLE only)
req_n  input  N_W  factorial operand
resp_valid  output  1  response available
resp_ready  input  1  consumer accepts response
resp_result  output  DATA_W  factorial result (0 on error)
resp_err  output  1  accelerator error flag or timeout
resp_timeout  output  1  poll limit exceeded
bus_a  output  2  register address: 00 input, 01 go, 10 status, 11 result
bus_we  output  1  bus write enable
bus_wd  output  N_W  bus write data
bus_rd  input  DATA_W  combinational read data; status bit0=done, bit1=err

Behaviour:
- Reset (async, immediate): state=IDLE, req_ready=1, resp_valid=0, resp_result=0, resp_err=0, resp_timeout=0, bus_a=10, bus_we=0, bus_wd=0, poll counter=0.
- All bus_* outputs are registered or decoded from state only; no combinational path from bus_rd to bus outputs.
- IDLE: req_ready=1, bus_we=0, bus_a=10. On req_valid&req_ready at an edge: latch req_n -> WR_N.
- WR_N (1 cycle): bus_a=00, bus_we=1, bus_wd=latched n -> WR_GO.
- WR_GO (1 cycle): bus_a=01, bus_we=1, bus_wd=1 -> SETTLE.
- SETTLE (1 cycle): bus_a=10, bus_we=0. bus_rd is ignored, because a stale done from the previous run may still be visible. Clear poll counter -> POLL.
- POLL: bus_a=10, bus_we=0. Sampled at each edge, in priority order:
  - bus_rd[1]=1: load resp_err=1, resp_timeout=0, resp_result=0 -> RESP.
  - else bus_rd[0]=1 -> RD_RES.
  - else if counter==POLL_LIMIT-1: load resp_err=1, resp_timeout=1, resp_result=0 -> RESP.
  - else counter+1.
  - err has priority over done when both are set.
- RD_RES (1 cycle): bus_a=11, bus_we=0. At the edge, capture bus_rd into resp_result, resp_err=0, resp_timeout=0 -> RESP.
- RESP: resp_valid=1. resp_result/resp_err/resp_timeout are stable while resp_valid=1 and resp_ready=0. On resp_ready -> IDLE, resp_valid=0 at the next cycle.
  - Response fields hold their values after the handshake until the next RESP load.
- Latency: acceptance edge E0; WR_N, WR_GO, SETTLE cycles follow. If done is seen on the first POLL cycle, resp_valid rises after E5 (5 cycles minimum). Each extra poll cycle adds 1.
- req_ready=0 in every state but IDLE. req_valid/req_n are ignored outside IDLE, and a new request is not accepted in the same cycle as a response handshake.
- n=0 is forwarded unchanged; the result is whatever the accelerator returns. Width: req_n is zero-extended/truncated to N_W on bus_wd.
- Reset mid-operation (any state): immediate return to IDLE with reset values. bus_we drops asynchronously, and no partial response is emitted.

Test Plan:
1. Behavioural slave, done 1 cycle after go; req n=3 -> resp_result=6, resp_err=0, resp_valid exactly 5 cycles after acceptance. Bus trace: a=00/we=1/wd=3, then a=01/we=1/wd=1, then a=10, a=10, a=11.
2. Req n=13, slave raises status bit1 -> resp_err=1, resp_timeout=0, resp_result=0, and no access to address 11.
3. Slave never sets done, POLL_LIMIT=64 -> resp_err=1, resp_timeout=1, resp_valid after exactly 3+64 cycles from acceptance.
4. Stale done=1 held during SETTLE, then cleared and reasserted 4 cycles later -> no early RD_RES; result read only after the reassertion.
5. resp_ready low for 10 cycles in RESP -> resp_valid and fields are constant and req_ready=0; req_valid pulses are ignored. After resp_ready: IDLE, then the next request is accepted.
6. Back-to-back requests n=1..12 with resp_ready=1 -> results 1,2,6,...,479001600, all err=0. Separately, assert rst mid-POLL -> bus_we=0 and resp_valid=0 immediately; the next request n=5 -> 120.
